// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline types: datapath widths, ALU operation encoding
// and the control bits that survive into the M stage.
package rv32i_pkg;

  localparam int DPW = 32;
  localparam int ADW = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_t;

  typedef struct packed {
    logic resultsrc;
    logic memwrite;
    logic regwrite;
  } m_ctrl_t;

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational RV32I ALU; unknown operation encodings produce zero.
module alu
  import rv32i_pkg::*;
(
  input  logic [DPW-1:0] a,
  input  logic [DPW-1:0] b,
  input  alu_op_t        alu_ctrl,
  output logic [DPW-1:0] result,
  output logic           zero
);

  always_comb begin
    result = '0;
    case (alu_ctrl)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLT:  result = {{(DPW-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(DPW-1){1'b0}}, (a < b)};
      ALU_SLL:  result = a << b[4:0];
      ALU_SRL:  result = a >> b[4:0];
      ALU_SRA:  result = DPW'($signed(a) >>> b[4:0]);
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/execute_stage.sv
// RV32I execute stage: operand selection, ALU and the E->M pipeline register.
// Define EXEC_FORWARDING_EN to add M/W -> E operand forwarding muxes.
module execute_stage
  import rv32i_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           resultsrcE,
  input  logic           memwriteE,
  input  logic           alusrcE,
  input  logic           regwriteE,
  input  alu_op_t        alu_ctrlE,
  input  logic [DPW-1:0] srcA,
  input  logic [DPW-1:0] Rd2E,
  input  logic [31:0]    immextE,
  input  logic [ADW-1:0] RdE,
  input  logic [ADW-1:0] Rs1E,
  input  logic [ADW-1:0] Rs2E,
  input  logic [DPW-1:0] ResultW,
  input  logic [ADW-1:0] RdW,
  input  logic           regwriteW,
  input  logic           stallE,
  input  logic           flushE,
  output logic           resultsrcM,
  output logic           memwriteM,
  output logic           regwriteM,
  output logic [DPW-1:0] alu_resultM,
  output logic [DPW-1:0] WriteDataM,
  output logic [ADW-1:0] RdM,
  output logic           zeroE
);

  m_ctrl_t        ctrl_d, ctrl_q;
  logic [DPW-1:0] alu_result_d, alu_result_q;
  logic [DPW-1:0] write_data_d, write_data_q;
  logic [ADW-1:0] rd_d, rd_q;

  logic [DPW-1:0] op_a, op_b_pre, op_b, alu_result;

`ifdef EXEC_FORWARDING_EN
  // The M stage is younger than W, so its value wins when both match.
  function automatic logic [DPW-1:0] fwd_sel(input logic [ADW-1:0] rs,
                                             input logic [DPW-1:0] rf_val);
    if (rs != '0 && rs == rd_q && ctrl_q.regwrite)
      return alu_result_q;
    else if (rs != '0 && rs == RdW && regwriteW)
      return ResultW;
    else
      return rf_val;
  endfunction

  assign op_a     = fwd_sel(Rs1E, srcA);
  assign op_b_pre = fwd_sel(Rs2E, Rd2E);
`else
  logic unused_fwd;
  assign unused_fwd = ^{Rs1E, Rs2E, ResultW, RdW, regwriteW};
  assign op_a       = srcA;
  assign op_b_pre   = Rd2E;
`endif

  assign op_b = alusrcE ? immextE : op_b_pre;

  alu u_alu (
    .a        (op_a),
    .b        (op_b),
    .alu_ctrl (alu_ctrlE),
    .result   (alu_result),
    .zero     (zeroE)
  );

  // Flush inserts a bubble even while the stage is stalled.
  always_comb begin
    ctrl_d       = ctrl_q;
    alu_result_d = alu_result_q;
    write_data_d = write_data_q;
    rd_d         = rd_q;
    if (flushE) begin
      ctrl_d       = '0;
      alu_result_d = '0;
      write_data_d = '0;
      rd_d         = '0;
    end else if (!stallE) begin
      ctrl_d       = '{resultsrc: resultsrcE, memwrite: memwriteE, regwrite: regwriteE};
      alu_result_d = alu_result;
      write_data_d = op_b_pre;
      rd_d         = RdE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q       <= '0;
      alu_result_q <= '0;
      write_data_q <= '0;
      rd_q         <= '0;
    end else begin
      ctrl_q       <= ctrl_d;
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      rd_q         <= rd_d;
    end
  end

  assign resultsrcM  = ctrl_q.resultsrc;
  assign memwriteM   = ctrl_q.memwrite;
  assign regwriteM   = ctrl_q.regwrite;
  assign alu_resultM = alu_result_q;
  assign WriteDataM  = write_data_q;
  assign RdM         = rd_q;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage; forwarding cases run when
// EXEC_FORWARDING_EN is defined for the build.
module tb_execute_stage;
  import rv32i_pkg::*;

  logic        clk, rst_n;
  logic        resultsrcE, memwriteE, alusrcE, regwriteE;
  alu_op_t     alu_ctrlE;
  logic [31:0] srcA, Rd2E, immextE, ResultW;
  logic [4:0]  RdE, Rs1E, Rs2E, RdW;
  logic        regwriteW, stallE, flushE;
  logic        resultsrcM, memwriteM, regwriteM, zeroE;
  logic [31:0] alu_resultM, WriteDataM;
  logic [4:0]  RdM;

  typedef struct packed {
    logic        resultsrc;
    logic        memwrite;
    logic        regwrite;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  rd;
  } m_exp_t;

  m_exp_t sb[$];
  m_exp_t m_model;
  int     checks = 0;
  int     errors = 0;

  execute_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .resultsrcE  (resultsrcE),
    .memwriteE   (memwriteE),
    .alusrcE     (alusrcE),
    .regwriteE   (regwriteE),
    .alu_ctrlE   (alu_ctrlE),
    .srcA        (srcA),
    .Rd2E        (Rd2E),
    .immextE     (immextE),
    .RdE         (RdE),
    .Rs1E        (Rs1E),
    .Rs2E        (Rs2E),
    .ResultW     (ResultW),
    .RdW         (RdW),
    .regwriteW   (regwriteW),
    .stallE      (stallE),
    .flushE      (flushE),
    .resultsrcM  (resultsrcM),
    .memwriteM   (memwriteM),
    .regwriteM   (regwriteM),
    .alu_resultM (alu_resultM),
    .WriteDataM  (WriteDataM),
    .RdM         (RdM),
    .zeroE       (zeroE)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic checkM(input string tag, input m_exp_t exp);
    checkOutput({tag, ".resultsrcM"}, {31'b0, resultsrcM}, {31'b0, exp.resultsrc});
    checkOutput({tag, ".memwriteM"},  {31'b0, memwriteM},  {31'b0, exp.memwrite});
    checkOutput({tag, ".regwriteM"},  {31'b0, regwriteM},  {31'b0, exp.regwrite});
    checkOutput({tag, ".alu_resultM"}, alu_resultM, exp.alu);
    checkOutput({tag, ".WriteDataM"},  WriteDataM,  exp.wd);
    checkOutput({tag, ".RdM"}, {27'b0, RdM}, {27'b0, exp.rd});
  endtask

  function automatic logic [31:0] modelAlu(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_SLL:  return a << b[4:0];
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return 32'($signed(a) >>> b[4:0]);
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] modelFwd(input logic [4:0] rs, input logic [31:0] rfVal);
`ifdef EXEC_FORWARDING_EN
    if (rs != 5'd0 && rs == m_model.rd && m_model.regwrite) return m_model.alu;
    if (rs != 5'd0 && rs == RdW && regwriteW) return ResultW;
`endif
    return rfVal;
  endfunction

  // Drive one E-stage bundle, check zeroE combinationally, then compare M after the edge.
  task automatic applyStimulus(input string tag, input alu_op_t op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] imm, input logic alusrc,
                               input logic [4:0] rd, input logic [2:0] ctrl,
                               input logic stall, input logic flush);
    m_exp_t nxt, exp;
    logic [31:0] opA, bPre, res;
    alu_ctrlE  = op;
    srcA       = a;
    Rd2E       = b;
    immextE    = imm;
    alusrcE    = alusrc;
    RdE        = rd;
    resultsrcE = ctrl[2];
    memwriteE  = ctrl[1];
    regwriteE  = ctrl[0];
    stallE     = stall;
    flushE     = flush;
    opA  = modelFwd(Rs1E, a);
    bPre = modelFwd(Rs2E, b);
    res  = modelAlu(op, opA, alusrc ? imm : bPre);
    if (flush)      nxt = '0;
    else if (stall) nxt = m_model;
    else            nxt = '{ctrl[2], ctrl[1], ctrl[0], res, bPre, rd};
    sb.push_back(nxt);
    #1;
    checkOutput({tag, ".zeroE"}, {31'b0, zeroE}, {31'b0, (res == 32'd0)});
    @(posedge clk);
    #1;
    exp = sb.pop_front();
    m_model = exp;
    checkM(tag, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    {resultsrcE, memwriteE, alusrcE, regwriteE, regwriteW, stallE, flushE} = '0;
    alu_ctrlE = ALU_ADD;
    {srcA, Rd2E, immextE, ResultW} = '0;
    {RdE, Rs1E, Rs2E, RdW} = '0;
    m_model = '0;

    #2 checkM("reset", '0);
    #5 rst_n = 1'b1;
    #1 checkM("post_release", '0);
    @(posedge clk);
    #1;

    applyStimulus("add",  ALU_ADD,  32'd5, 32'd7, 32'd0, 1'b0, 5'd3, 3'b001, 1'b0, 1'b0);
    applyStimulus("sub",  ALU_SUB,  32'd5, 32'd5, 32'd0, 1'b0, 5'd4, 3'b101, 1'b0, 1'b0);
    applyStimulus("slt",  ALU_SLT,  32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 5'd5, 3'b001, 1'b0, 1'b0);
    applyStimulus("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 5'd6, 3'b001, 1'b0, 1'b0);
    applyStimulus("sra",  ALU_SRA,  32'h8000_0000, 32'd4, 32'd0, 1'b0, 5'd7, 3'b001, 1'b0, 1'b0);
    applyStimulus("srl",  ALU_SRL,  32'h8000_0000, 32'd36, 32'd0, 1'b0, 5'd8, 3'b001, 1'b0, 1'b0);
    applyStimulus("sll",  ALU_SLL,  32'h0000_0003, 32'd31, 32'd0, 1'b0, 5'd9, 3'b001, 1'b0, 1'b0);
    applyStimulus("and",  ALU_AND,  32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 1'b0, 5'd10, 3'b010, 1'b0, 1'b0);
    applyStimulus("or",   ALU_OR,   32'hF0F0_0000, 32'h0000_1234, 32'd0, 1'b0, 5'd11, 3'b001, 1'b0, 1'b0);
    applyStimulus("xor",  ALU_XOR,  32'hAAAA_5555, 32'hFFFF_0000, 32'd0, 1'b0, 5'd12, 3'b001, 1'b0, 1'b0);
    applyStimulus("undef", alu_op_t'(4'hF), 32'd9, 32'd9, 32'd0, 1'b0, 5'd13, 3'b001, 1'b0, 1'b0);
    applyStimulus("addi", ALU_ADD,  32'd16, 32'd55, 32'hFFFF_FFFC, 1'b1, 5'd14, 3'b011, 1'b0, 1'b0);
    applyStimulus("wrap", ALU_ADD,  32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 5'd15, 3'b001, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++)
      applyStimulus($sformatf("stall%0d", i), ALU_XOR, 32'd100 + i, 32'd3 * i, 32'd0, 1'b0,
                    5'(20 + i), 3'b110, 1'b1, 1'b0);
    applyStimulus("unstall",    ALU_SUB, 32'd50, 32'd8, 32'd0, 1'b0, 5'd21, 3'b001, 1'b0, 1'b0);
    applyStimulus("flushstall", ALU_ADD, 32'd1, 32'd2, 32'd0, 1'b0, 5'd22, 3'b111, 1'b1, 1'b1);
    applyStimulus("reload",     ALU_OR,  32'd6, 32'd9, 32'd0, 1'b0, 5'd23, 3'b001, 1'b0, 1'b0);

    // Asynchronous reset between edges, then reset during a stall.
    #2 rst_n = 1'b0;
    m_model = '0;
    #1 checkM("async_reset", '0);
    #1 rst_n = 1'b1;
    #1 checkM("reset_hold", '0);
    @(posedge clk);
    #1;
    applyStimulus("preload",  ALU_ADD, 32'd40, 32'd2, 32'd0, 1'b0, 5'd24, 3'b101, 1'b0, 1'b0);
    applyStimulus("stall_a",  ALU_ADD, 32'd77, 32'd1, 32'd0, 1'b0, 5'd25, 3'b001, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    m_model = '0;
    #1 checkM("reset_in_stall", '0);
    #1 rst_n = 1'b1;
    applyStimulus("stall_b",  ALU_ADD, 32'd77, 32'd1, 32'd0, 1'b0, 5'd25, 3'b001, 1'b1, 1'b0);

`ifdef EXEC_FORWARDING_EN
    Rs1E = 5'd0; Rs2E = 5'd0;
    applyStimulus("fwd_x1", ALU_ADD, 32'd10, 32'd0, 32'd1, 1'b1, 5'd1, 3'b001, 1'b0, 1'b0);
    Rs1E = 5'd1; Rs2E = 5'd1;
    applyStimulus("fwd_x2", ALU_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 5'd2, 3'b001, 1'b0, 1'b0);
    Rs1E = 5'd0; Rs2E = 5'd0;
    applyStimulus("fwd_ld4", ALU_ADD, 32'd9, 32'd0, 32'd0, 1'b0, 5'd4, 3'b001, 1'b0, 1'b0);
    RdW = 5'd4; ResultW = 32'd7; regwriteW = 1'b1; Rs1E = 5'd4;
    applyStimulus("fwd_mprio", ALU_ADD, 32'd100, 32'd0, 32'd0, 1'b0, 5'd5, 3'b001, 1'b0, 1'b0);
    applyStimulus("fwd_wonly", ALU_ADD, 32'd100, 32'd1, 32'd0, 1'b0, 5'd6, 3'b001, 1'b0, 1'b0);
    Rs1E = 5'd0; RdW = 5'd0; ResultW = 32'd99;
    applyStimulus("fwd_ld0", ALU_ADD, 32'd5, 32'd0, 32'd0, 1'b0, 5'd0, 3'b001, 1'b0, 1'b0);
    applyStimulus("fwd_x0",  ALU_ADD, 32'd3, 32'd0, 32'd0, 1'b0, 5'd7, 3'b001, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the 5-stage RV32I pipeline: consumes the E-stage bundle registered by the decode stage, selects operands, runs the ALU and registers the result plus the surviving control bits into the E→M pipeline register. It is the reader of the D→E register and the writer of the M-stage inputs. Stall and flush controls come from the hazard unit.

## Interface
- `DPW`, 32 (from `rv32i_pkg`): datapath width.
- `ADW`, 5: register-address width.

- `clk`  in  1  pipeline clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `resultsrcE, memwriteE, alusrcE, regwriteE`  in  1 each  E-stage control.
- `alu_ctrlE`  in  `alu_op_t`  ALU operation.
- `srcA, Rd2E`  in  DPW  register-file operands.
- `immextE`  in  32  sign-extended immediate.
- `RdE, Rs1E, Rs2E`  in  ADW  destination and source register numbers.
- `ResultW`  in  DPW  writeback-stage result.
- `RdW`  in  ADW  writeback destination.
- `regwriteW`  in  1  writeback write enable.
- `stallE`  in  1  hold the M register.
- `flushE`  in  1  load a bubble into the M register.
- `resultsrcM, memwriteM, regwriteM`  out  1 each  M-stage control.
- `alu_resultM`  out  DPW  registered ALU result.
- `WriteDataM`  out  DPW  registered store data (post-forwarding B operand).
- `RdM`  out  ADW  registered destination.
- `zeroE`  out  1  combinational: ALU result == 0 (for branch logic).

## Operation
- Operand A = forwarded `srcA`. Operand B pre-mux = forwarded `Rd2E`. Operand B = `alusrcE` ? `immextE` : B pre-mux.
- ALU ops: ADD, SUB, AND, OR, XOR, SLT (signed), SLTU, SLL, SRL, SRA. Shift amount = B[4:0]. Undefined encoding → result 0.
- Arithmetic wraps modulo 2^DPW; no overflow flag.
- M register, per rising edge:
  - `flushE`=1: all control outputs 0, `RdM`=0, data outputs 0. Flush wins over stall.
  - else `stallE`=1: hold all outputs.
  - else: load `resultsrcE, memwriteE, regwriteE`, ALU result, B pre-mux, `RdE`.
- `alusrcE` and `alu_ctrlE` are consumed in E and are not forwarded to M.

## Timing
- Latency 1 cycle: E-stage inputs at edge N appear on M outputs after edge N+1.
- `zeroE` is combinational, same cycle.
- Reset (`rst_n`=0, asynchronous): every M output 0 immediately; it stays 0 until the first edge after release. Reset mid-stall clears held contents.
- Forwarding path (when compiled in) is a single combinational cycle from the M/W registers. No extra latency.
- Stall held for k cycles leaves outputs unchanged for k edges. Releasing the stall loads the then-present E inputs.

## Configuration
- `EXEC_FORWARDING_EN` defined: forwarding muxes for both operands.
  - Source matches `RdM`, `regwriteM`=1, and the source is not x0 → use `alu_resultM`.
  - else source matches `RdW`, `regwriteW`=1, and the source is not x0 → use `ResultW`.
  - else use the register-file value.
  - M has priority over W.
- Not defined: operands taken directly from `srcA`/`Rd2E`. `Rs1E, Rs2E, ResultW, RdW, regwriteW` remain as ports but are ignored.

## Structure
- `rv32i_pkg`: `DPW`, `alu_op_t` enum (ALU_ADD … ALU_SRA), and an M-stage control struct type.
- One sub-module: `alu` (combinational; inputs a, b, `alu_ctrl`; outputs result, zero).
- Forwarding muxes and the M register live in `execute_stage`.

## Test plan
- Reset: drive `rst_n`=0 mid-operation. All M outputs must be 0 asynchronously, before the next edge.
- ADD, `alusrcE`=0, srcA=5, Rd2E=7, RdE=3, regwriteE=1 → after 1 edge: `alu_resultM`=12, `RdM`=3, `regwriteM`=1, `WriteDataM`=7.
- SUB 5−5 → `zeroE`=1 in the same cycle. SLT −1 vs 1 → 1. SLTU 0xFFFFFFFF vs 1 → 0. SRA 0x80000000 by 4 → 0xF8000000.
- `alusrcE`=1, immextE=0xFFFFFFFC, srcA=16, ADD → `alu_resultM`=12. `WriteDataM` still equals Rd2E.
- Stall for 3 cycles with changing inputs → outputs frozen. Assert `flushE` and `stallE` together → bubble, all outputs 0.
- With `EXEC_FORWARDING_EN` defined:
  - back-to-back `x1=10+1`, then `x2=x1+x1` → second result 22, M priority.
  - RdM=RdW=4, both write, alu_resultM=9, ResultW=7 → 9 used.
  - Rs1E=0 with RdM=0 → no forwarding.
